// File: rtl/bus_master_if.sv
// bus_master_if: latches one CPU access, requests the bus, strobes and waits for ready.
// Optional access timeout enabled by defining BUS_TIMEOUT_EN.
module bus_master_if #(
    parameter int ADDR_W         = 30,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic              bus_req,
    input  logic              bus_grnt,
    output logic              bus_as,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic              bus_rdy,
    input  logic [DATA_W-1:0] bus_rd_data
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACCESS
    } state_t;

    state_t state;
    logic   rdy_ok;

    // A slave ready only counts while we actually own the bus.
    assign rdy_ok = bus_rdy & bus_grnt;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                           $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt;
    logic             timed_out;

    assign timed_out = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign cpu_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cpu_rd_data <= '0;
            cpu_busy    <= 1'b0;
            cpu_done    <= 1'b0;
            bus_req     <= 1'b0;
            bus_as      <= 1'b0;
            bus_rw      <= 1'b0;
            bus_addr    <= '0;
            bus_wr_data <= '0;
`ifdef BUS_TIMEOUT_EN
            cpu_err     <= 1'b0;
            cnt         <= '0;
`endif
        end else begin
            cpu_done <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            cpu_err  <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    bus_req <= cpu_req;
                    if (cpu_req) begin
                        state       <= REQ;
                        cpu_busy    <= 1'b1;
                        bus_rw      <= cpu_rw;
                        bus_addr    <= cpu_addr;
                        bus_wr_data <= cpu_wr_data;
                    end
                end
                REQ: begin
                    if (bus_grnt) begin
                        state  <= ACCESS;
                        bus_as <= 1'b1;
`ifdef BUS_TIMEOUT_EN
                        cnt    <= '0;
`endif
                    end
                end
                ACCESS: begin
                    bus_as <= 1'b0;
                    if (rdy_ok) begin
                        if (bus_rw) cpu_rd_data <= bus_rd_data;
                        // Keep the request up if the CPU is already queuing the next access.
                        bus_req     <= cpu_req;
                        state       <= IDLE;
                        cpu_busy    <= 1'b0;
                        cpu_done    <= 1'b1;
                        bus_rw      <= 1'b0;
                        bus_addr    <= '0;
                        bus_wr_data <= '0;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (timed_out) begin
                        if (bus_rw) cpu_rd_data <= '0;
                        bus_req     <= 1'b0;
                        state       <= IDLE;
                        cpu_busy    <= 1'b0;
                        cpu_done    <= 1'b1;
                        cpu_err     <= 1'b1;
                        bus_rw      <= 1'b0;
                        bus_addr    <= '0;
                        bus_wr_data <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_if.sv
// tb_bus_master_if: directed scenarios for bus_master_if.
// Timeout scenario follows BUS_TIMEOUT_EN with TIMEOUT_CYCLES=8.
module tb_bus_master_if;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_rw;
    logic [29:0] cpu_addr;
    logic [31:0] cpu_wr_data;
    logic [31:0] cpu_rd_data;
    logic        cpu_busy;
    logic        cpu_done;
    logic        cpu_err;
    logic        bus_req;
    logic        bus_grnt;
    logic        bus_as;
    logic        bus_rw;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data;
    logic        bus_rdy;
    logic [31:0] bus_rd_data;

    int checks = 0;
    int errors = 0;

    wire [99:0] all_out = {cpu_rd_data, cpu_busy, cpu_done, cpu_err,
                           bus_req, bus_as, bus_rw, bus_addr, bus_wr_data};

    bus_master_if #(
        .ADDR_W(30),
        .DATA_W(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cpu_req(cpu_req),
        .cpu_rw(cpu_rw),
        .cpu_addr(cpu_addr),
        .cpu_wr_data(cpu_wr_data),
        .cpu_rd_data(cpu_rd_data),
        .cpu_busy(cpu_busy),
        .cpu_done(cpu_done),
        .cpu_err(cpu_err),
        .bus_req(bus_req),
        .bus_grnt(bus_grnt),
        .bus_as(bus_as),
        .bus_rw(bus_rw),
        .bus_addr(bus_addr),
        .bus_wr_data(bus_wr_data),
        .bus_rdy(bus_rdy),
        .bus_rd_data(bus_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cpu_req = 0; cpu_rw = 0; cpu_addr = '0; cpu_wr_data = '0;
        bus_grnt = 0; bus_rdy = 0; bus_rd_data = '0;
        step(); step();
        checks++;
        if (all_out !== 100'd0) begin
            errors++; $display("FAIL reset_outs: got %h expected 0", all_out);
        end
        rst = 1'b1;
        step();
        checks++;
        if (all_out !== 100'd0) begin
            errors++; $display("FAIL reset_idle: got %h expected 0", all_out);
        end
    endtask

    task automatic test_read();
        bus_grnt = 1;
        cpu_req = 1; cpu_rw = 1; cpu_addr = 30'h1000_0004;
        step();
        cpu_req = 0;
        checks++;
        if ({cpu_busy, bus_req, bus_as, cpu_done} !== 4'b1100) begin
            errors++; $display("FAIL rd_req: got %b expected 1100",
                               {cpu_busy, bus_req, bus_as, cpu_done});
        end
        step();
        checks++;
        if ({cpu_busy, bus_as, bus_rw, cpu_done} !== 4'b1110 ||
            bus_addr !== 30'h1000_0004) begin
            errors++; $display("FAIL rd_as: got %b %h expected 1110 10000004",
                               {cpu_busy, bus_as, bus_rw, cpu_done}, bus_addr);
        end
        bus_rdy = 1; bus_rd_data = 32'hDEAD_BEEF;
        step();
        bus_rdy = 0;
        checks++;
        if ({cpu_done, cpu_err, cpu_busy, bus_req, bus_as} !== 5'b10000 ||
            cpu_rd_data !== 32'hDEAD_BEEF || bus_addr !== 30'd0) begin
            errors++; $display("FAIL rd_done: got %b %h %h expected 10000 deadbeef 0",
                               {cpu_done, cpu_err, cpu_busy, bus_req, bus_as},
                               cpu_rd_data, bus_addr);
        end
        step();
        checks++;
        if (cpu_done !== 1'b0 || cpu_rd_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rd_pulse: got %b %h expected 0 deadbeef",
                               cpu_done, cpu_rd_data);
        end
    endtask

    task automatic test_write();
        bus_grnt = 0;
        cpu_req = 1; cpu_rw = 0; cpu_addr = 30'h0800_0000;
        cpu_wr_data = 32'h1234_5678;
        step();
        cpu_req = 0;
        checks++;
        if (bus_req !== 1'b1 || cpu_busy !== 1'b1) begin
            errors++; $display("FAIL wr_req: got %b%b expected 11", bus_req, cpu_busy);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({bus_req, bus_as, cpu_busy, cpu_done} !== 4'b1010) begin
                errors++; $display("FAIL wr_wait%0d: got %b expected 1010", i,
                                   {bus_req, bus_as, cpu_busy, cpu_done});
            end
        end
        bus_grnt = 1;
        step();
        checks++;
        if (bus_as !== 1'b1 || bus_rw !== 1'b0 ||
            bus_addr !== 30'h0800_0000 || bus_wr_data !== 32'h1234_5678) begin
            errors++; $display("FAIL wr_as: got %b %b %h %h expected 1 0 8000000 12345678",
                               bus_as, bus_rw, bus_addr, bus_wr_data);
        end
        bus_rdy = 1; bus_rd_data = 32'h5555_AAAA;
        step();
        bus_rdy = 0;
        checks++;
        if (cpu_done !== 1'b1 || cpu_rd_data !== 32'hDEAD_BEEF || bus_req !== 1'b0) begin
            errors++; $display("FAIL wr_done: got %b %h %b expected 1 deadbeef 0",
                               cpu_done, cpu_rd_data, bus_req);
        end
    endtask

    task automatic test_wait_states();
        bus_grnt = 1;
        cpu_req = 1; cpu_rw = 1; cpu_addr = 30'h0000_0123;
        step();
        cpu_req = 0;
        cpu_addr = 30'h3FFF_FFFF;
        step();
        checks++;
        if (bus_as !== 1'b1 || bus_addr !== 30'h0000_0123) begin
            errors++; $display("FAIL ws_as: got %b %h expected 1 123", bus_as, bus_addr);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                bus_grnt = 0; bus_rdy = 1; bus_rd_data = 32'hBAD0_BAD0;
            end
            step();
            bus_grnt = 1; bus_rdy = 0;
            checks++;
            if (bus_as !== 1'b0 || cpu_done !== 1'b0 || cpu_busy !== 1'b1 ||
                bus_addr !== 30'h0000_0123) begin
                errors++; $display("FAIL ws_hold%0d: got %b%b%b %h expected 001 123", i,
                                   bus_as, cpu_done, cpu_busy, bus_addr);
            end
        end
        bus_rdy = 1; bus_rd_data = 32'hCAFE_0001;
        step();
        bus_rdy = 0;
        checks++;
        if (cpu_done !== 1'b1 || cpu_rd_data !== 32'hCAFE_0001) begin
            errors++; $display("FAIL ws_done: got %b %h expected 1 cafe0001",
                               cpu_done, cpu_rd_data);
        end
    endtask

    task automatic test_back_to_back();
        bus_grnt = 1;
        cpu_req = 1; cpu_rw = 1; cpu_addr = 30'h0000_0A00;
        step();
        cpu_addr = 30'h0000_0B00;
        step();
        checks++;
        if (bus_as !== 1'b1 || bus_addr !== 30'h0000_0A00) begin
            errors++; $display("FAIL b2b_as1: got %b %h expected 1 a00", bus_as, bus_addr);
        end
        bus_rdy = 1; bus_rd_data = 32'h1111_0001;
        step();
        bus_rdy = 0;
        checks++;
        if (cpu_done !== 1'b1 || bus_req !== 1'b1 || cpu_rd_data !== 32'h1111_0001) begin
            errors++; $display("FAIL b2b_done1: got %b %b %h expected 1 1 11110001",
                               cpu_done, bus_req, cpu_rd_data);
        end
        step();
        cpu_req = 0;
        checks++;
        if ({cpu_busy, bus_req, cpu_done} !== 3'b110 || bus_addr !== 30'h0000_0B00) begin
            errors++; $display("FAIL b2b_req2: got %b %h expected 110 b00",
                               {cpu_busy, bus_req, cpu_done}, bus_addr);
        end
        step();
        checks++;
        if (bus_as !== 1'b1 || bus_req !== 1'b1) begin
            errors++; $display("FAIL b2b_as2: got %b%b expected 11", bus_as, bus_req);
        end
        bus_rdy = 1; bus_rd_data = 32'h2222_0002;
        step();
        bus_rdy = 0;
        checks++;
        if (cpu_done !== 1'b1 || bus_req !== 1'b0 || cpu_rd_data !== 32'h2222_0002) begin
            errors++; $display("FAIL b2b_done2: got %b %b %h expected 1 0 22220002",
                               cpu_done, bus_req, cpu_rd_data);
        end
    endtask

    task automatic test_timeout();
        bus_grnt = 1; bus_rdy = 0;
        cpu_req = 1; cpu_rw = 1; cpu_addr = 30'h0000_0777;
        step();
        cpu_req = 0;
        step();
`ifdef BUS_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            step();
            checks++;
            if (cpu_done !== 1'b0 || cpu_busy !== 1'b1) begin
                errors++; $display("FAIL to_wait%0d: got %b%b expected 01", i,
                                   cpu_done, cpu_busy);
            end
        end
        step();
        checks++;
        if ({cpu_done, cpu_err, bus_req, cpu_busy} !== 4'b1100 || cpu_rd_data !== 32'd0) begin
            errors++; $display("FAIL to_abort: got %b %h expected 1100 0",
                               {cpu_done, cpu_err, bus_req, cpu_busy}, cpu_rd_data);
        end
        step();
        checks++;
        if (cpu_done !== 1'b0 || cpu_err !== 1'b0) begin
            errors++; $display("FAIL to_pulse: got %b%b expected 00", cpu_done, cpu_err);
        end
`else
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({cpu_busy, bus_req, cpu_done, cpu_err} !== 4'b1100) begin
                errors++; $display("FAIL to_hang%0d: got %b expected 1100", i,
                                   {cpu_busy, bus_req, cpu_done, cpu_err});
            end
        end
        rst = 0;
        step();
        rst = 1;
        step();
`endif
    endtask

    task automatic test_reset_mid_access();
        bus_grnt = 1; bus_rdy = 0;
        cpu_req = 1; cpu_rw = 1; cpu_addr = 30'h0000_0345;
        step();
        cpu_req = 0;
        step();
        step();
        rst = 0;
        bus_rdy = 1; bus_rd_data = 32'h7777_7777;
        #1;
        checks++;
        if (all_out !== 100'd0) begin
            errors++; $display("FAIL rstmid_async: got %h expected 0", all_out);
        end
        step();
        checks++;
        if (all_out !== 100'd0) begin
            errors++; $display("FAIL rstmid_nodone: got %h expected 0", all_out);
        end
        rst = 1; bus_rdy = 0;
        step();
        cpu_req = 1; cpu_rw = 0; cpu_addr = 30'h0000_0099;
        cpu_wr_data = 32'h0BAD_F00D;
        step();
        cpu_req = 0;
        step();
        checks++;
        if (bus_as !== 1'b1 || bus_wr_data !== 32'h0BAD_F00D || bus_addr !== 30'h0000_0099) begin
            errors++; $display("FAIL rstmid_as: got %b %h %h expected 1 0badf00d 99",
                               bus_as, bus_wr_data, bus_addr);
        end
        bus_rdy = 1;
        step();
        bus_rdy = 0;
        checks++;
        if (cpu_done !== 1'b1 || cpu_rd_data !== 32'd0) begin
            errors++; $display("FAIL rstmid_done: got %b %h expected 1 0",
                               cpu_done, cpu_rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_wait_states();
        test_back_to_back();
        test_timeout();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
